fifo_wr_arbiter: RTL and testbench

Shares the write port of the async FIFO write-side pointer/full logic among NUM_REQ requesters in the write clock domain. Each requester presents a valid/ready stream; the arbiter picks one round-robin, holds it for a bounded burst, and drives `winc`/`wdata` only when the FIFO is not full. It sits directly in front of the FIFO write port, and no write is ever issued against an asserted `full`.

---
 rtl/fifo_wr_arbiter_pkg.sv | 24 ++
 rtl/fifo_wr_arbiter_if.sv | 27 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter:
// state encoding, index-width helper and saturating increment.
package fifo_wr_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] limit);
    logic [63:0] result;
    if (value >= limit) begin
      result = value;
    end else begin
      result = value + 64'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester streams plus FIFO write port and status of the write-port arbiter.
// master = requesters/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          full;
  logic                          winc;
  logic [DATA_WIDTH-1:0]         wdata;
  logic [NUM_REQ-1:0]            grant;
  logic                          busy;
  logic [CNT_WIDTH-1:0]          stall_cnt;

  modport master (
    output req_valid, req_data, full,
    input  req_ready, winc, wdata, grant, busy, stall_cnt
  );

  modport slave (
    input  req_valid, req_data, full,
    output req_ready, winc, wdata, grant, busy, stall_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Rotating-priority picker: first set bit of valid at or above ptr, wrapping
// modulo NUM_REQ.
module rr_pick
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IW-1:0]      ptr,
  output logic               found,
  output logic [IW-1:0]      idx
);

  // Scan from the farthest offset down so the nearest valid index wins.
  always_comb begin
    logic [IW:0]   sum;
    logic [IW-1:0] j;
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      sum   = {1'b0, ptr} + (IW+1)'(k);
      j     = (sum >= (IW+1)'(NUM_REQ)) ? IW'(sum - (IW+1)'(NUM_REQ)) : IW'(sum);
      found = found | valid[j];
      idx   = valid[j] ? j : idx;
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async-FIFO write port among NUM_REQ streams.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to MAX_BURST transfers.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input logic               wclk,
  input logic               rst,
  fifo_wr_arbiter_if.slave  bus
);

  localparam int IW = idx_width(NUM_REQ);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t               state;
  logic [NUM_REQ-1:0]   cur_grant;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        rr_ptr;
  logic                 busy_flag;
  logic [CNT_WIDTH-1:0] stall_count;

  logic                 found;
  logic [IW-1:0]        pick_idx;
  logic [NUM_REQ-1:0]   pick_onehot;
  logic                 in_burst;
  logic                 owner_valid;
  logic                 winc_now;
  logic                 last_beat;
  logic                 release_now;
  logic                 stall_now;
  logic [IW-1:0]        next_ptr;
  logic [DATA_WIDTH-1:0] wdata_mux;

  rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // One-hot form of the picked index for the grant register.
  always_comb begin
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pick_onehot[i] = (pick_idx == IW'(i));
    end
  end

  // Data mux driven by the one-hot grant; zero while no owner is held.
  always_comb begin
    wdata_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata_mux = wdata_mux | ({DATA_WIDTH{cur_grant[i]}} & bus.req_data[i*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  // A word seen while reset is asserted is neither acknowledged nor written.
  assign in_burst    = (state == ST_BURST);
  assign owner_valid = |(bus.req_valid & cur_grant);
  assign winc_now    = in_burst & owner_valid & ~bus.full & ~rst;
  assign stall_now   = in_burst & owner_valid & bus.full;
  assign release_now = in_burst & ((winc_now & last_beat) | ~owner_valid);
  assign next_ptr    = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BW = idx_width(MAX_BURST);
  logic [BW-1:0] beat_cnt;

  assign last_beat = (beat_cnt == BW'(MAX_BURST - 1));

  // Transfers completed within the current grant.
  always_ff @(posedge wclk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (release_now) begin
      beat_cnt <= '0;
    end else if (winc_now) begin
      beat_cnt <= beat_cnt + BW'(1);
    end else begin
      beat_cnt <= beat_cnt;
    end
  end
`else
  assign last_beat = 1'b1;
`endif

  // Arbitration FSM, grant/pointer registers and stall counter.
  always_ff @(posedge wclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      cur_grant   <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      busy_flag   <= 1'b0;
      stall_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            state     <= ST_BURST;
            cur_grant <= pick_onehot;
            owner     <= pick_idx;
            busy_flag <= 1'b1;
          end
        end
        ST_BURST: begin
          if (release_now) begin
            state     <= ST_IDLE;
            cur_grant <= '0;
            busy_flag <= 1'b0;
            rr_ptr    <= next_ptr;
          end
        end
        default: begin
          state     <= ST_IDLE;
          cur_grant <= '0;
          busy_flag <= 1'b0;
        end
      endcase
      if (stall_now) begin
        stall_count <= CNT_WIDTH'(sat_inc(64'(stall_count), 64'(CNT_MAX)));
      end
    end
  end

  assign bus.req_ready = (in_burst & ~bus.full & ~rst) ? cur_grant : '0;
  assign bus.winc      = winc_now;
  assign bus.wdata     = wdata_mux;
  assign bus.grant     = cur_grant;
  assign bus.busy      = busy_flag;
  assign bus.stall_cnt = stall_count;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter; expectations follow
// FIFO_WR_ARB_BURST_EN (4-beat bursts) or its absence (single-word grants).
module tb_fifo_wr_arbiter;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int BURST_LEN = 4;
`else
  localparam int BURST_LEN = 1;
`endif
  localparam int PRE_STALL = (BURST_LEN > 1) ? 1 : 0;
  localparam int PRE_DROP  = (BURST_LEN > 2) ? 2 : 0;

  logic        wclk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic        full;
  int          checks = 0;
  int          passes = 0;

  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(16)) bus ();
  fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8), .CNT_WIDTH(4))  sbus ();

  assign bus.req_valid  = req_valid;
  assign bus.req_data   = req_data;
  assign bus.full       = full;
  assign sbus.req_valid = req_valid;
  assign sbus.req_data  = req_data;
  assign sbus.full      = full;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(16)) dut (
    .wclk (wclk),
    .rst  (rst),
    .bus  (bus)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4), .CNT_WIDTH(4)) dut_small (
    .wclk (wclk),
    .rst  (rst),
    .bus  (sbus)
  );

  always #5 wclk = ~wclk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = 4'b0000;
    req_data = 32'h0;
    full = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    req_data = 32'h55AA55AA;
    full = 1'b0;
    tick();
    tick();
    @(negedge wclk);
    checks++;
    if ({bus.grant, bus.busy, bus.req_ready, bus.winc, bus.wdata} !== {4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got %h required %h", {bus.grant, bus.busy, bus.req_ready, bus.winc, bus.wdata}, 18'h0);
    else passes++;
    checks++;
    if ({bus.stall_cnt, sbus.stall_cnt} !== 20'h0)
      $display("FAIL reset_stall: got %h required %h", {bus.stall_cnt, sbus.stall_cnt}, 20'h0);
    else passes++;
    tick();
    rst = 1'b0;
    req_valid = 4'b0000;
  endtask

  task automatic test_single();
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b0001;
    req_data = 32'h00000011;
    @(negedge wclk);
    checks++;
    if ({bus.winc, bus.grant, bus.req_ready} !== {1'b0, 4'b0000, 4'b0000})
      $display("FAIL single_latency: got %h required %h", {bus.winc, bus.grant, bus.req_ready}, 9'h0);
    else passes++;
    tick();
    for (int b = 0; b < 4; b++) begin
      exp_d = 8'(8'h11 + b);
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.wdata, bus.grant, bus.req_ready, bus.busy} !== {1'b1, exp_d, 4'b0001, 4'b0001, 1'b1})
        $display("FAIL single_beat%0d: got %h required %h", b,
                 {bus.winc, bus.wdata, bus.grant, bus.req_ready, bus.busy}, {1'b1, exp_d, 4'b0001, 4'b0001, 1'b1});
      else passes++;
      tick();
      if (b == 3) req_valid = 4'b0000;
      else req_data[7:0] = 8'(8'h12 + b);
      if (((b + 1) % BURST_LEN) == 0) begin
        @(negedge wclk);
        checks++;
        if ({bus.winc, bus.grant, bus.busy} !== {1'b0, 4'b0000, 1'b0})
          $display("FAIL single_bubble%0d: got %h required %h", b, {bus.winc, bus.grant, bus.busy}, 6'h0);
        else passes++;
        tick();
      end
    end
  endtask

  task automatic test_rr();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b1111;
    req_data = 32'hA3A2A1A0;
    @(negedge wclk);
    checks++;
    if ({bus.winc, bus.grant} !== 5'h0)
      $display("FAIL rr_idle: got %h required %h", {bus.winc, bus.grant}, 5'h0);
    else passes++;
    tick();
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'(1 << (n % 4));
      exp_d = 8'(8'hA0 + (n % 4));
      for (int b = 0; b < BURST_LEN; b++) begin
        @(negedge wclk);
        checks++;
        if ({bus.grant, bus.req_ready, bus.winc, bus.wdata} !== {exp_g, exp_g, 1'b1, exp_d})
          $display("FAIL rr_grant%0d_beat%0d: got %h required %h", n, b,
                   {bus.grant, bus.req_ready, bus.winc, bus.wdata}, {exp_g, exp_g, 1'b1, exp_d});
        else passes++;
        tick();
      end
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.grant, bus.busy} !== 6'h0)
        $display("FAIL rr_bubble%0d: got %h required %h", n, {bus.winc, bus.grant, bus.busy}, 6'h0);
      else passes++;
      tick();
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_stall();
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b0100;
    req_data = 32'h00C00000;
    tick();
    for (int b = 0; b < PRE_STALL; b++) begin
      exp_d = 8'(8'hC0 + b);
      req_data[23:16] = exp_d;
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.wdata} !== {1'b1, exp_d})
        $display("FAIL stall_pre%0d: got %h required %h", b, {bus.winc, bus.wdata}, {1'b1, exp_d});
      else passes++;
      tick();
    end
    req_data[23:16] = 8'(8'hC0 + PRE_STALL);
    full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.req_ready, bus.grant, bus.busy} !== {1'b0, 4'b0000, 4'b0100, 1'b1})
        $display("FAIL stall_hold%0d: got %h required %h", s,
                 {bus.winc, bus.req_ready, bus.grant, bus.busy}, {1'b0, 4'b0000, 4'b0100, 1'b1});
      else passes++;
      tick();
    end
    full = 1'b0;
    checks++;
    if (bus.stall_cnt !== 16'd5)
      $display("FAIL stall_count: got %0d required %0d", bus.stall_cnt, 5);
    else passes++;
    for (int b = PRE_STALL; b < BURST_LEN; b++) begin
      exp_d = 8'(8'hC0 + b);
      req_data[23:16] = exp_d;
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.wdata, bus.req_ready} !== {1'b1, exp_d, 4'b0100})
        $display("FAIL stall_resume%0d: got %h required %h", b,
                 {bus.winc, bus.wdata, bus.req_ready}, {1'b1, exp_d, 4'b0100});
      else passes++;
      tick();
    end
    req_valid = 4'b0000;
    @(negedge wclk);
    checks++;
    if ({bus.grant, bus.busy} !== 5'h0)
      $display("FAIL stall_release: got %h required %h", {bus.grant, bus.busy}, 5'h0);
    else passes++;
    tick();
  endtask

  task automatic test_drop();
    logic [7:0] exp_d;
    do_reset();
    req_valid = 4'b0010;
    req_data = 32'h0000D000;
    tick();
    for (int b = 0; b < PRE_DROP; b++) begin
      exp_d = 8'(8'hD0 + b);
      req_data[15:8] = exp_d;
      @(negedge wclk);
      checks++;
      if ({bus.winc, bus.wdata, bus.grant} !== {1'b1, exp_d, 4'b0010})
        $display("FAIL drop_beat%0d: got %h required %h", b, {bus.winc, bus.wdata, bus.grant}, {1'b1, exp_d, 4'b0010});
      else passes++;
      tick();
    end
    req_valid = 4'b0101;
    req_data = 32'h00E000B0;
    @(negedge wclk);
    checks++;
    if ({bus.winc, bus.grant, bus.busy} !== {1'b0, 4'b0010, 1'b1})
      $display("FAIL drop_idle_owner: got %h required %h", {bus.winc, bus.grant, bus.busy}, {1'b0, 4'b0010, 1'b1});
    else passes++;
    tick();
    @(negedge wclk);
    checks++;
    if ({bus.winc, bus.grant, bus.busy} !== 6'h0)
      $display("FAIL drop_bubble: got %h required %h", {bus.winc, bus.grant, bus.busy}, 6'h0);
    else passes++;
    tick();
    @(negedge wclk);
    checks++;
    if ({bus.grant, bus.winc, bus.wdata} !== {4'b0100, 1'b1, 8'hE0})
      $display("FAIL drop_next_grant: got %h required %h", {bus.grant, bus.winc, bus.wdata}, {4'b0100, 1'b1, 8'hE0});
    else passes++;
    tick();
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid = 4'b0010;
    req_data = 32'h00626251;
    tick();
    req_valid = 4'b0100;
    tick();
    tick();
    full = 1'b1;
    tick();
    full = 1'b0;
    rst = 1'b1;
    @(negedge wclk);
    checks++;
    if ({bus.winc, bus.req_ready, bus.grant, bus.stall_cnt} !== {1'b0, 4'b0000, 4'b0100, 16'd1})
      $display("FAIL rstmid_before: got %h required %h",
               {bus.winc, bus.req_ready, bus.grant, bus.stall_cnt}, {1'b0, 4'b0000, 4'b0100, 16'd1});
    else passes++;
    tick();
    rst = 1'b0;
    req_valid = 4'b1111;
    @(negedge wclk);
    checks++;
    if ({bus.grant, bus.busy, bus.stall_cnt, bus.winc, bus.req_ready, bus.wdata} !== 34'h0)
      $display("FAIL rstmid_after: got %h required %h",
               {bus.grant, bus.busy, bus.stall_cnt, bus.winc, bus.req_ready, bus.wdata}, 34'h0);
    else passes++;
    tick();
    checks++;
    if (bus.grant !== 4'b0001)
      $display("FAIL rstmid_rearb: got %b required %b", bus.grant, 4'b0001);
    else passes++;
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_sat();
    do_reset();
    req_valid = 4'b0001;
    req_data = 32'h00000077;
    tick();
    full = 1'b1;
    for (int s = 0; s < 20; s++) begin
      tick();
      if (s == 13) begin
        checks++;
        if (sbus.stall_cnt !== 4'hE)
          $display("FAIL sat_progress: got %h required %h", sbus.stall_cnt, 4'hE);
        else passes++;
      end
    end
    checks++;
    if ({sbus.stall_cnt, bus.stall_cnt, bus.grant} !== {4'hF, 16'd20, 4'b0001})
      $display("FAIL sat_limit: got %h required %h", {sbus.stall_cnt, bus.stall_cnt, bus.grant}, {4'hF, 16'd20, 4'b0001});
    else passes++;
    full = 1'b0;
    req_valid = 4'b0000;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 4'b0000;
    req_data = 32'h0;
    full = 1'b0;
    test_reset();
    test_single();
    test_rr();
    test_stall();
    test_drop();
    test_reset_mid();
    test_sat();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
